// File: rtl/alu_exec_unit_if.sv
// Handshake bus for alu_exec_unit: operation request in, held result out.
// The producer/consumer side uses master, the execution unit uses slave.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [3:0]      alu_ctrl;

    modport master (
        output in_valid, alu_op, funct7, funct3, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, alu_ctrl
    );

    modport slave (
        input  in_valid, alu_op, funct7, funct3, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, alu_ctrl
    );
endinterface

// File: rtl/alu_exec_unit.sv
// RISC-V ALU execution unit: decodes alu_op/funct7/funct3, runs single-cycle ops
// or an iterative shift-add MUL, and holds the result until the consumer takes it.
module alu_exec_unit #(
    parameter int unsigned XLEN   = 64,
    parameter bit          MUL_EN = 1'b1
) (
    input logic          clk,
    input logic          reset,
    alu_exec_unit_if.slave bus
);
    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_MUL, S_DONE} state_t;

    state_t          state;
    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] acc_q;
    logic [SHW-1:0]  cnt_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;
    logic [3:0]      ctrl_q;

    logic            accept_c;
    logic [3:0]      dec_c;
    logic [XLEN-1:0] exec_c;
    logic [XLEN-1:0] load_c;
    logic [SHW-1:0]  shamt_c;
    logic            slt_c;
    logic            sltu_c;

    assign bus.in_ready  = (state == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
    assign bus.alu_ctrl  = ctrl_q;

    assign accept_c = bus.in_valid && bus.in_ready;

    function automatic logic [3:0] f3_map(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    // Instruction-field decode into the extended op code
    always_comb begin
        dec_c = OP_ILL;
        case (bus.alu_op)
            2'b00: dec_c = OP_ADD;
            2'b01: dec_c = OP_SUB;
            2'b10: begin
                if (bus.funct7 == 7'b0000000) begin
                    dec_c = f3_map(bus.funct3);
                end else if (bus.funct7 == 7'b0100000 && bus.funct3 == 3'b000) begin
                    dec_c = OP_SUB;
                end else if (bus.funct7 == 7'b0100000 && bus.funct3 == 3'b101) begin
                    dec_c = OP_SRA;
                end else if (MUL_EN && bus.funct7 == 7'b0000001 && bus.funct3 == 3'b000) begin
                    dec_c = OP_MUL;
                end
            end
            default: begin
                if (bus.funct3 == 3'b001) begin
                    if (bus.funct7[6:1] == 6'b000000) dec_c = OP_SLL;
                end else if (bus.funct3 == 3'b101) begin
                    if (bus.funct7[6:1] == 6'b000000)      dec_c = OP_SRL;
                    else if (bus.funct7[6:1] == 6'b010000) dec_c = OP_SRA;
                end else begin
                    dec_c = f3_map(bus.funct3);
                end
            end
        endcase
    end

    assign shamt_c = b_q[SHW-1:0];
    assign slt_c   = $signed(a_q) < $signed(b_q);
    assign sltu_c  = a_q < b_q;

    // Single-cycle datapath on the captured operands; MUL and ILLEGAL yield 0 here
    always_comb begin
        exec_c = '0;
        case (op_q)
            OP_AND:  exec_c = a_q & b_q;
            OP_OR:   exec_c = a_q | b_q;
            OP_ADD:  exec_c = a_q + b_q;
            OP_XOR:  exec_c = a_q ^ b_q;
            OP_SLL:  exec_c = a_q << shamt_c;
            OP_SRL:  exec_c = a_q >> shamt_c;
            OP_SUB:  exec_c = a_q - b_q;
            OP_SRA:  exec_c = $unsigned($signed(a_q) >>> shamt_c);
            OP_SLT:  exec_c = {{(XLEN-1){1'b0}}, slt_c};
            OP_SLTU: exec_c = {{(XLEN-1){1'b0}}, sltu_c};
            default: exec_c = '0;
        endcase
    end

    assign load_c = (state == S_DONE) ? acc_q : exec_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            ctrl_q      <= 4'b0000;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        a_q   <= bus.op_a;
                        b_q   <= bus.op_b;
                        op_q  <= dec_c;
                        acc_q <= '0;
                        cnt_q <= '0;
                        state <= (dec_c == OP_MUL) ? S_MUL : S_ISSUE;
                    end
                end
                // One shift-add step per clock: a_q is the multiplicand, b_q the multiplier
                S_MUL: begin
                    if (b_q[0]) acc_q <= acc_q + a_q;
                    a_q <= a_q << 1;
                    b_q <= b_q >> 1;
                    if (cnt_q == SHW'(XLEN - 1)) state <= S_DONE;
                    else cnt_q <= cnt_q + SHW'(1);
                end
                S_ISSUE, S_DONE: begin
                    result_q    <= load_c;
                    zero_q      <= (load_c == '0);
                    illegal_q   <= (op_q == OP_ILL);
                    ctrl_q      <= op_q;
                    out_valid_q <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomised and directed bench for alu_exec_unit at XLEN=64 and XLEN=8,
// checked against a plain-arithmetic reference model.
module tb_alu_exec_unit;
    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011;
    localparam logic [3:0] C_SLL = 4'b0100, C_SRL = 4'b0101, C_SUB = 4'b0110, C_SRA = 4'b0111;
    localparam logic [3:0] C_SLT = 4'b1000, C_SLTU = 4'b1001, C_MUL = 4'b1010, C_ILL = 4'b1111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_unit_if #(.XLEN(64)) b64 ();
    alu_exec_unit_if #(.XLEN(8))  b8 ();

    alu_exec_unit #(.XLEN(64), .MUL_EN(1'b1)) u64 (.clk(clk), .reset(reset), .bus(b64.slave));
    alu_exec_unit #(.XLEN(8),  .MUL_EN(1'b1)) u8  (.clk(clk), .reset(reset), .bus(b8.slave));

    bit          sel;
    logic        t_in_valid, t_out_ready;
    logic [1:0]  t_op;
    logic [6:0]  t_f7;
    logic [2:0]  t_f3;
    logic [63:0] t_a, t_b;

    assign b64.in_valid  = t_in_valid & ~sel;
    assign b8.in_valid   = t_in_valid & sel;
    assign b64.out_ready = t_out_ready & ~sel;
    assign b8.out_ready  = t_out_ready & sel;
    assign b64.alu_op = t_op;  assign b8.alu_op = t_op;
    assign b64.funct7 = t_f7;  assign b8.funct7 = t_f7;
    assign b64.funct3 = t_f3;  assign b8.funct3 = t_f3;
    assign b64.op_a = t_a;     assign b8.op_a = t_a[7:0];
    assign b64.op_b = t_b;     assign b8.op_b = t_b[7:0];

    logic        s_in_ready, s_out_valid, s_zero, s_illegal;
    logic [63:0] s_result;
    logic [3:0]  s_ctrl;
    assign s_in_ready  = sel ? b8.in_ready  : b64.in_ready;
    assign s_out_valid = sel ? b8.out_valid : b64.out_valid;
    assign s_zero      = sel ? b8.zero      : b64.zero;
    assign s_illegal   = sel ? b8.illegal   : b64.illegal;
    assign s_ctrl      = sel ? b8.alu_ctrl  : b64.alu_ctrl;
    assign s_result    = sel ? {56'd0, b8.result} : b64.result;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: decode tables plus 64-bit arithmetic truncated to xl bits
    function automatic void model(input int xl, input logic [1:0] op, input logic [6:0] f7,
                                  input logic [2:0] f3, input logic [63:0] a_in,
                                  input logic [63:0] b_in, output logic [3:0] code,
                                  output logic [63:0] res);
        logic [3:0]  map [8];
        logic [63:0] mask, a, b;
        logic signed [63:0] as_, bs_;
        int sh;
        map = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
        mask = (xl == 64) ? {64{1'b1}} : ((64'd1 << xl) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        as_ = $signed(a << (64 - xl)) >>> (64 - xl);
        bs_ = $signed(b << (64 - xl)) >>> (64 - xl);
        sh = int'(b % 64'(xl));
        code = C_ILL;
        case (op)
            2'd0: code = C_ADD;
            2'd1: code = C_SUB;
            2'd2: begin
                if (f7 == 7'h00) code = map[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) code = C_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) code = C_SRA;
                else if (f7 == 7'h01 && f3 == 3'd0) code = C_MUL;
            end
            default: begin
                if (f3 == 3'd1) code = (f7[6:1] == 6'd0) ? C_SLL : C_ILL;
                else if (f3 == 3'd5) code = (f7[6:1] == 6'd0) ? C_SRL :
                                            (f7[6:1] == 6'b010000) ? C_SRA : C_ILL;
                else code = map[f3];
            end
        endcase
        case (code)
            C_AND:  res = a & b;
            C_OR:   res = a | b;
            C_ADD:  res = a + b;
            C_XOR:  res = a ^ b;
            C_SLL:  res = a << sh;
            C_SRL:  res = a >> sh;
            C_SUB:  res = a - b;
            C_SRA:  res = $unsigned(as_ >>> sh);
            C_SLT:  res = (as_ < bs_) ? 64'd1 : 64'd0;
            C_SLTU: res = (a < b) ? 64'd1 : 64'd0;
            C_MUL:  res = a * b;
            default: res = 64'd0;
        endcase
        res = res & mask;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!s_in_ready && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 64'(s_in_ready), 64'd1);
    endtask

    // Issue one op, check latency/busy/result, hold for 'hold' cycles, optionally consume
    task automatic run_op(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] b, input int hold,
                          input bit consume);
        int xl, lat;
        bit busy_ok, stable;
        logic [3:0] ec;
        logic [63:0] er, held;
        xl = sel ? 8 : 64;
        model(xl, op, f7, f3, a, b, ec, er);
        wait_ready();
        t_op = op; t_f7 = f7; t_f3 = f3; t_a = a; t_b = b; t_in_valid = 1'b1;
        @(posedge clk); #1;
        t_in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!s_out_valid && lat < 200) begin
            if (s_in_ready) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        check("latency", 64'(lat), (ec == C_MUL) ? 64'(xl + 1) : 64'd1);
        check("busy_in_ready_low", 64'(busy_ok), 64'd1);
        check("result", s_result, er);
        check("alu_ctrl", 64'(s_ctrl), 64'(ec));
        check("illegal", 64'(s_illegal), (ec == C_ILL) ? 64'd1 : 64'd0);
        check("zero", 64'(s_zero), (er == 64'd0) ? 64'd1 : 64'd0);
        if (hold > 0) begin
            held = s_result;
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (s_result !== held || !s_out_valid || s_in_ready || s_ctrl !== ec) stable = 1'b0;
            end
            check("hold_stable", 64'(stable), 64'd1);
        end
        if (consume) begin
            t_out_ready = 1'b1;
            @(posedge clk); #1;
            t_out_ready = 1'b0;
            check("consumed", 64'(s_out_valid), 64'd0);
        end
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return 64'($urandom_range(0, 3));
            1: return 64'h8000_0000_0000_0000;
            2: return {64{1'b1}};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic random_ops(input int n);
        logic [6:0] f7;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                3: f7 = {6'b010000, 1'($urandom)};
                default: f7 = 7'($urandom);
            endcase
            run_op(2'($urandom_range(0, 3)), f7, 3'($urandom_range(0, 7)),
                   rand_operand(), rand_operand(), $urandom_range(0, 2), 1'b1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit no_stale;
        sel = 1'b0;
        t_in_valid = 1'b0; t_out_ready = 1'b0;
        t_op = '0; t_f7 = '0; t_f3 = '0; t_a = '0; t_b = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(s_out_valid), 64'd0);
        check("rst_result", s_result, 64'd0);
        check("rst_zero", 64'(s_zero), 64'd0);
        check("rst_illegal", 64'(s_illegal), 64'd0);
        check("rst_alu_ctrl", 64'(s_ctrl), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(s_in_ready), 64'd1);

        run_op(2'b10, 7'h00, 3'd0, 64'd5, 64'd7, 0, 1'b1);
        check("add_5_7", s_result, 64'd12);
        run_op(2'b10, 7'h20, 3'd0, 64'd3, 64'd3, 0, 1'b1);
        run_op(2'b10, 7'h20, 3'd5, 64'h8000_0000_0000_0000, 64'd4, 0, 1'b1);
        check("sra_const", s_result, 64'hF800_0000_0000_0000);
        run_op(2'b10, 7'h00, 3'd2, {64{1'b1}}, 64'd1, 0, 1'b1);
        run_op(2'b10, 7'h00, 3'd3, {64{1'b1}}, 64'd1, 0, 1'b1);
        run_op(2'b11, 7'h21, 3'd5, 64'hF0, 64'd4, 0, 1'b1);
        run_op(2'b11, 7'h20, 3'd1, 64'hF0, 64'd4, 0, 1'b1);

        sel = 1'b1;
        run_op(2'b10, 7'h01, 3'd0, 64'd13, 64'd11, 0, 1'b1);
        check("mul8_13x11", s_result, 64'h8F);
        run_op(2'b10, 7'h00, 3'd1, 64'h81, 64'd9, 0, 1'b1);

        // Hold, then back-to-back accept on the consuming edge
        sel = 1'b0;
        run_op(2'b00, 7'h00, 3'd0, 64'd100, 64'd23, 5, 1'b0);
        t_op = 2'b00; t_a = 64'd40; t_b = 64'd2;
        t_in_valid = 1'b1; t_out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 64'(s_in_ready), 64'd1);
        @(posedge clk); #1;
        t_in_valid = 1'b0; t_out_ready = 1'b0;
        check("b2b_valid_clear", 64'(s_out_valid), 64'd0);
        check("b2b_busy", 64'(s_in_ready), 64'd0);
        @(posedge clk); #1;
        check("b2b_valid", 64'(s_out_valid), 64'd1);
        check("b2b_result", s_result, 64'd42);
        t_out_ready = 1'b1;
        @(posedge clk); #1;
        t_out_ready = 1'b0;

        run_op(2'b10, 7'h01, 3'd0, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)}, 1, 1'b1);

        // Reset during MUL iteration 3
        wait_ready();
        t_op = 2'b10; t_f7 = 7'h01; t_f3 = 3'd0; t_a = 64'd7; t_b = 64'd9; t_in_valid = 1'b1;
        @(posedge clk); #1;
        t_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midmul_rst_valid", 64'(s_out_valid), 64'd0);
        check("midmul_rst_result", s_result, 64'd0);
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        check("midmul_in_ready", 64'(s_in_ready), 64'd1);
        no_stale = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (s_out_valid) no_stale = 1'b0;
        end
        check("midmul_discarded", 64'(no_stale), 64'd1);
        run_op(2'b10, 7'h7F, 3'd0, 64'd9, 64'd9, 0, 1'b1);

        random_ops(200);
        sel = 1'b1;
        random_ops(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
